writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/wb_pkg.sv | 18 +
 rtl/writeback_arbiter_if.sv | 30 +++
 rtl/wb_pending_fifo.sv | 86 ++++++++
 rtl/writeback_arbiter.sv | 102 ++++++++++
 tb/tb_writeback_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared widths, default sizing and the pending-buffer entry record for the
// writeback arbiter.
package wb_pkg;

    localparam int unsigned DATA_W               = 32;
    localparam int unsigned REG_ADDR_W           = 5;
    localparam int unsigned NUM_REGS             = 32;
    localparam int unsigned DEFAULT_DEPTH        = 4;
    localparam int unsigned DEFAULT_STARVE_LIMIT = 8;

    // live=0 marks an entry overwritten by a younger pipeline write.
    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } entry_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Pipeline, long-latency and register-file signals of the writeback arbiter.
interface writeback_arbiter_if;
    import wb_pkg::*;

    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0]     wb_data;

    logic                  ll_valid;
    logic                  ll_ready;
    logic [REG_ADDR_W-1:0] ll_rd;
    logic [DATA_W-1:0]     ll_data;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_wr;
    logic [DATA_W-1:0]     rf_wdata;
    logic [NUM_REGS-1:0]   pending_mask;
    logic                  stall_req;

    modport master (
        output wb_we, wb_rd, wb_data, ll_valid, ll_rd, ll_data,
        input  ll_ready, rf_we, rf_wr, rf_wdata, pending_mask, stall_req
    );

    modport slave (
        input  wb_we, wb_rd, wb_data, ll_valid, ll_rd, ll_data,
        output ll_ready, rf_we, rf_wr, rf_wdata, pending_mask, stall_req
    );

endinterface

// File: rtl/wb_pending_fifo.sv
// In-order buffer of long-latency results with squash-by-rd and a registered
// mask of the registers still owed a write by a live entry.
module wb_pending_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic [REG_ADDR_W-1:0]     push_rd_i,
    input  logic [DATA_W-1:0]         push_data_i,
    input  logic                      pop_i,
    input  logic                      squash_i,
    input  logic [REG_ADDR_W-1:0]     squash_rd_i,
    output entry_t                    head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [NUM_REGS-1:0]       pending_mask_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    entry_t [DEPTH-1:0]  mem_q, mem_d;
    logic [PtrW-1:0]     head_q, head_d;
    logic [PtrW-1:0]     tail_q, tail_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [NUM_REGS-1:0] mask_q, mask_d;

    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        mask_d = '0;

        // Squash only touches entries already present; the push below is exempt.
        if (squash_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (mem_q[i].rd == squash_rd_i) begin
                    mem_d[i].live = 1'b0;
                end
            end
        end

        if (pop_i) begin
            head_d = head_q + PtrW'(1);
        end

        if (push_i) begin
            mem_d[tail_q] = '{live: 1'b1, rd: push_rd_i, data: push_data_i};
            tail_d        = tail_q + PtrW'(1);
        end

        cnt_d = cnt_q + CntW'(push_i) - CntW'(pop_i);

        // A slot counts only if it sits between the next head and next tail.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            logic [PtrW-1:0] off;
            off = PtrW'(i) - head_d;
            if (mem_d[i].live && (CntW'(off) < cnt_d)) begin
                mask_d[mem_d[i].rd] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            mask_q <= '0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            mask_q <= mask_d;
        end
    end

    assign head_o         = mem_q[head_q];
    assign count_o        = cnt_q;
    assign pending_mask_o = mask_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Single-port register-file writeback arbiter: the pipeline has priority,
// long-latency results wait in a buffer and raise stall_req if starved.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input logic                clk,
    input logic                rst,
    writeback_arbiter_if.slave bus
);

    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam int unsigned WaitW = $clog2(STARVE_LIMIT + 1);

    entry_t                head;
    logic [CntW-1:0]       count;
    logic [NUM_REGS-1:0]   pending_mask;
    logic                  pipe_pick;
    logic                  buf_pick;
    logic                  push;

    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_wr_q, rf_wr_d;
    logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;
    logic [WaitW-1:0]      wait_q, wait_d;
    logic                  stall_q, stall_d;

    assign bus.ll_ready = !rst && (count < CntW'(DEPTH));

    assign pipe_pick = bus.wb_we && (bus.wb_rd != '0);
    assign buf_pick  = !pipe_pick && (count != '0);
    // rd=0 results are accepted but never stored.
    assign push      = bus.ll_valid && bus.ll_ready && (bus.ll_rd != '0);

    wb_pending_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .push_i         (push),
        .push_rd_i      (bus.ll_rd),
        .push_data_i    (bus.ll_data),
        .pop_i          (buf_pick),
        .squash_i       (pipe_pick),
        .squash_rd_i    (bus.wb_rd),
        .head_o         (head),
        .count_o        (count),
        .pending_mask_o (pending_mask)
    );

    always_comb begin
        rf_we_d    = 1'b0;
        rf_wr_d    = '0;
        rf_wdata_d = '0;
        if (pipe_pick) begin
            rf_we_d    = 1'b1;
            rf_wr_d    = bus.wb_rd;
            rf_wdata_d = bus.wb_data;
        end else if (buf_pick && head.live) begin
            rf_we_d    = 1'b1;
            rf_wr_d    = head.rd;
            rf_wdata_d = head.data;
        end
    end

    // Saturating wait counter; stall stays up until the buffer gets a pop.
    always_comb begin
        if ((count == '0) || buf_pick) begin
            wait_d = '0;
        end else if (wait_q < WaitW'(STARVE_LIMIT)) begin
            wait_d = wait_q + WaitW'(1);
        end else begin
            wait_d = wait_q;
        end
        stall_d = (wait_d >= WaitW'(STARVE_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_wr_q    <= '0;
            rf_wdata_q <= '0;
            wait_q     <= '0;
            stall_q    <= 1'b0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_wr_q    <= rf_wr_d;
            rf_wdata_q <= rf_wdata_d;
            wait_q     <= wait_d;
            stall_q    <= stall_d;
        end
    end

    assign bus.rf_we        = rf_we_q;
    assign bus.rf_wr        = rf_wr_q;
    assign bus.rf_wdata     = rf_wdata_q;
    assign bus.pending_mask = pending_mask;
    assign bus.stall_req    = stall_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomised and directed stimulus against a queue-based reference model;
// expected writes and per-cycle status go through scoreboards to a monitor.
module tb_writeback_arbiter;
    import wb_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 8;

    typedef struct {
        bit          live;
        logic [4:0]  rd;
        logic [31:0] data;
    } ment_t;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          cyc;
        logic [31:0] mask;
        bit          stall;
        bit          ready;
    } st_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    ment_t       mq[$];
    wr_t         wr_q[$];
    st_t         st_q[$];
    logic [31:0] exp_mask = '0;
    bit          exp_stall = 1'b0;
    int          mwait = 0;
    bit          have_exp = 1'b0;

    writeback_arbiter_if bus ();

    writeback_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    endtask

    // Drive one cycle of stimulus and advance the reference model by one cycle.
    task automatic step(input bit we, input logic [4:0] wrd, input logic [31:0] wdat,
                        input bit llv, input logic [4:0] lrd, input logic [31:0] ldat,
                        input bit r);
        bit ready;
        bit popped;
        bit nonempty;
        ment_t e;
        rst          = r;
        bus.wb_we    = we;
        bus.wb_rd    = wrd;
        bus.wb_data  = wdat;
        bus.ll_valid = llv;
        bus.ll_rd    = lrd;
        bus.ll_data  = ldat;

        ready = !r && (mq.size() < DEPTH);
        if (have_exp) st_q.push_back('{cyc, exp_mask, exp_stall, ready});

        if (r) begin
            mq.delete();
            mwait     = 0;
            exp_mask  = '0;
            exp_stall = 1'b0;
        end else begin
            nonempty = (mq.size() != 0);
            popped   = 1'b0;
            if (we && wrd != 0) begin
                wr_q.push_back('{cyc + 1, wrd, wdat});
                foreach (mq[i]) if (mq[i].rd == wrd) mq[i].live = 1'b0;
            end else if (nonempty) begin
                e = mq.pop_front();
                popped = 1'b1;
                if (e.live) wr_q.push_back('{cyc + 1, e.rd, e.data});
            end
            if (llv && ready && lrd != 0) mq.push_back('{1'b1, lrd, ldat});

            if (nonempty && !popped) mwait = (mwait < LIMIT) ? mwait + 1 : mwait;
            else mwait = 0;
            exp_stall = (mwait >= LIMIT);
            exp_mask  = '0;
            foreach (mq[i]) if (mq[i].live) exp_mask[mq[i].rd] = 1'b1;
        end
        have_exp = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    // Monitor: per-cycle status plus write scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        st_t s;
        wr_t w;
        if (st_q.size() != 0) begin
            s = st_q.pop_front();
            chk("pending_mask", bus.pending_mask, s.mask);
            chk("stall_req", 32'(bus.stall_req), 32'(s.stall));
            chk("ll_ready", 32'(bus.ll_ready), 32'(s.ready));
            if (wr_q.size() != 0 && wr_q[0].cyc <= cyc) begin
                w = wr_q.pop_front();
                chk("rf_we", 32'(bus.rf_we), 32'd1);
                chk("rf_wr", 32'(bus.rf_wr), 32'(w.rd));
                chk("rf_wdata", bus.rf_wdata, w.data);
            end else begin
                chk("rf_we_idle", 32'(bus.rf_we), 32'd0);
            end
        end
    end

    initial begin
        bus.wb_we    = 1'b0;
        bus.wb_rd    = '0;
        bus.wb_data  = '0;
        bus.ll_valid = 1'b0;
        bus.ll_rd    = '0;
        bus.ll_data  = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        idle(8);

        // Plain pipeline write on an idle buffer.
        step(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0, 1'b0);
        idle(3);

        // Single long-latency result drains two cycles after accept.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h11, 1'b0);
        idle(4);

        // Fill under continuous pipeline writes, starve, then drain.
        for (int i = 0; i < 16; i++)
            step(1'b1, 5'd7, 32'h700 + 32'(i), i < 6, 5'(10 + i), 32'hB00 + 32'(i), 1'b0);
        idle(8);

        // WAW squash of a buffered entry.
        step(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h22, 1'b0);
        step(1'b1, 5'd9, 32'h33, 1'b0, 5'd0, 32'd0, 1'b0);
        idle(4);

        // Same-cycle accept and pipeline write to the same register.
        step(1'b1, 5'd4, 32'h55, 1'b1, 5'd4, 32'h44, 1'b0);
        idle(4);

        // Reset with three entries buffered, then rd=0 traffic.
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'd2, 32'h200 + 32'(i), i < 3, 5'(20 + i), 32'hC00 + 32'(i), 1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        idle(3);
        step(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 1'b0);
        step(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBEEF, 1'b0);
        idle(3);

        // Random traffic over a narrow register range to provoke squashes.
        for (int n = 0; n < 1500; n++) begin
            int unsigned wbp;
            bit r;
            wbp = ((n / 300) % 3 == 0) ? 30 : (((n / 300) % 3 == 1) ? 85 : 10);
            r   = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 99) < wbp, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom, r);
        end
        idle(24);

        chk("scoreboard_drained", 32'(wr_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
